spi_deserializer: RTL
=====================

# spi_deserializer

- Receive-side counterpart of the SPI serializer; lives on the same fabric clock.
- Samples the three-wire SPI link (SPI_clk, DataBit, CS) that drives the daughter-board attenuators, LSB first.
- Reassembles each fixed-length frame into a parallel word and hands it upstream over a valid/ready handshake.
- Used for loopback verification of the attenuator link and as a bench/readback receiver.

## Interface
- Register_Width, 32: width of Data_Out; must be ≥ Shift_BitCount.
- Shift_BitCount, 24: number of bits in one valid frame.
- Sync_Stages, 2: synchronizer depth for SPI inputs (≥ 2).
- clk  input  1  fabric clock; all logic on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- SPI_clk  input  1  serial clock, asynchronous to clk.
- DataBit  input  1  serial data, LSB first, stable around SPI_clk rising edge.
- CS  input  1  chip select, active low; frame active while low.
- Data_Out  output  Register_Width  received word, zero-extended above bit Shift_BitCount-1.
- Data_Valid  output  1  Data_Out holds an unconsumed word.
- Data_Ready  input  1  consumer accepts word when high with Data_Valid.
- Frame_Error  output  1  one-cycle pulse: frame closed with wrong bit count.
- Overrun  output  1  one-cycle pulse: good frame dropped because the output was still full.

## Operation
- Synchronize SPI_clk, DataBit and CS through Sync_Stages flops each.
  - Reset values: SPI_clk 0, DataBit 0, CS 1.
- Register the synchronized SPI_clk and CS once more.
  - SPI_clk rise = synchronized SPI_clk high and its delayed copy low.
  - CS rise and CS fall are detected the same way.
- FSM states:
  - WAIT_IDLE (reset state): stay until synchronized CS = 1, then go to IDLE. A frame already in progress at reset release is discarded.
  - IDLE: on CS fall, clear bit counter and shift register, go to RECV.
  - RECV:
    - On each SPI_clk rise, shift register <= {DataBit_sync, shreg[Shift_BitCount-1:1]}. The first bit received ends in bit 0.
    - On each SPI_clk rise, increment the bit counter, saturating at Shift_BitCount+1.
    - On CS rise, evaluate the frame and go to IDLE.
- Frame evaluation on CS rise:
  - If count == Shift_BitCount, the frame is good. Otherwise pulse Frame_Error, leave Data_Out unchanged, and leave Data_Valid unchanged.
  - Good frame with Data_Valid=0, or with Data_Valid=1 and Data_Ready=1 in the same cycle: load Data_Out, set Data_Valid=1.
  - Good frame with Data_Valid=1 and Data_Ready=0: drop the word, pulse Overrun, keep the old Data_Out.
- SPI_clk rise and CS rise in the same cycle: the rising SPI_clk edge is not sampled; only the CS rise is acted on.
- CS fall while in WAIT_IDLE: ignored.
- Handshake:
  - Data_Valid clears on the cycle after Data_Valid & Data_Ready, unless a good frame reloads it in that same cycle.
  - Data_Out holds its value while Data_Valid=0.
- Reset values: Data_Out 0, Data_Valid 0, Frame_Error 0, Overrun 0, state WAIT_IDLE, counter 0, shift register 0.
- rst_n assertion mid-frame clears everything immediately; no partial word is ever presented.

## Timing
- Input constraint: SPI_clk high and low times each ≥ Sync_Stages+2 clk cycles.
- Input constraint: DataBit stable from 1 clk before to Sync_Stages+1 clk after SPI_clk rises.
- Input constraint: CS low ≥ Sync_Stages+2 clk before the first SPI_clk rise.
- Input constraint: CS rises ≥ Sync_Stages+2 clk after the last SPI_clk rise.
- Latency from a pin transition to the corresponding internal edge: Sync_Stages+1 clk cycles.
- Data_Valid, Frame_Error and Overrun are driven at the clk edge following that.
- With the default Sync_Stages=2, Data_Valid rises 4 clk edges after CS rises at the pin, excluding synchronizer metastability jitter of ±1 cycle.
- Throughput: one word per frame. Minimum CS high time between frames: Sync_Stages+2 clk.

## Test plan
- Good frame: CS low, 24 SPI_clk rises (21-clk half period) carrying 0xA5C3F1 LSB first, then CS high.
  - Required: Data_Out = 0x00A5C3F1 and Data_Valid=1 four clk after the CS rise; Frame_Error=0.
- Short/long frame: 23 bits, then 25 bits.
  - Required: a single Frame_Error pulse each time; Data_Valid stays 0; Data_Out stays 0.
- Back-pressure: two good frames 0x000001 then 0xFFFFFF with Data_Ready=0 throughout.
  - Required: Data_Out = 0x00000001, one Overrun pulse on the second frame.
  - Then raise Data_Ready for 1 cycle. Required: Data_Valid=0 on the next cycle.
- Simultaneous accept: a second good frame (0x123456) completes in the same cycle the consumer accepts the first.
  - Required: Data_Valid stays 1, Data_Out = 0x00123456, no Overrun.
- Reset mid-frame: assert rst_n low after 10 bits, release it with CS still low, send the remaining 14 bits, raise CS.
  - Required: no Data_Valid and no Frame_Error.
  - Then send a full frame 0x0F0F0F. Required: Data_Out = 0x000F0F0F.
- Edge collision: drive SPI_clk rise and CS rise so they are synchronized in the same cycle, after 24 prior rises.
  - Required: the frame is still accepted as good.

Source files
------------

// File: rtl/spi_deserializer_if.sv
// Bundle of the serial pins and the parallel valid/ready output of the SPI deserializer.
// master: deserializer side; slave: link driver / word consumer side.
interface spi_deserializer_if #(
  parameter int unsigned Register_Width = 32
);
  logic                      SPI_clk;
  logic                      DataBit;
  logic                      CS;
  logic [Register_Width-1:0] Data_Out;
  logic                      Data_Valid;
  logic                      Data_Ready;
  logic                      Frame_Error;
  logic                      Overrun;

  modport master (
    input  SPI_clk,
    input  DataBit,
    input  CS,
    input  Data_Ready,
    output Data_Out,
    output Data_Valid,
    output Frame_Error,
    output Overrun
  );

  modport slave (
    output SPI_clk,
    output DataBit,
    output CS,
    output Data_Ready,
    input  Data_Out,
    input  Data_Valid,
    input  Frame_Error,
    input  Overrun
  );
endinterface

// File: rtl/spi_deserializer.sv
// Receives fixed-length LSB-first SPI frames on the fabric clock and presents each good
// frame as a parallel word over valid/ready, flagging bad-length frames and overruns.
module spi_deserializer #(
  parameter int unsigned Register_Width = 32,
  parameter int unsigned Shift_BitCount = 24,
  parameter int unsigned Sync_Stages    = 2
) (
  input logic              clk,
  input logic              rst_n,
  spi_deserializer_if.master bus
);

  localparam int unsigned CntW  = $clog2(Shift_BitCount + 2);
  localparam int unsigned WarmW = $clog2(Sync_Stages + 2);

  typedef enum logic [1:0] {StWaitIdle, StIdle, StRecv} state_e;

  state_e state_q, state_d;

  logic [Sync_Stages-1:0]    sclk_sync_q, data_sync_q, cs_sync_q;
  logic                      sclk_dly_q, data_dly_q, cs_dly_q;
  logic                      sclk_rise_q, cs_rise_q, cs_fall_q;
  logic [WarmW-1:0]          warm_q;
  logic                      warm_done;
  logic                      sclk_s, cs_s;

  logic [CntW-1:0]           cnt_q, cnt_d;
  logic [Shift_BitCount-1:0] shreg_q, shreg_d;
  logic [Register_Width-1:0] dout_q, dout_d;
  logic                      valid_q, valid_d;
  logic                      ferr_q, ferr_d;
  logic                      ovr_q, ovr_d;
  logic [Register_Width-1:0] word_ext;

  assign sclk_s    = sclk_sync_q[Sync_Stages-1];
  assign cs_s      = cs_sync_q[Sync_Stages-1];
  assign warm_done = (warm_q == WarmW'(Sync_Stages + 1));

  // Edge pulses are registered so that the data copy below lines up with the sampled edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      data_sync_q <= '0;
      cs_sync_q   <= '1;
      sclk_dly_q  <= 1'b0;
      data_dly_q  <= 1'b0;
      cs_dly_q    <= 1'b1;
      sclk_rise_q <= 1'b0;
      cs_rise_q   <= 1'b0;
      cs_fall_q   <= 1'b0;
      warm_q      <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[Sync_Stages-2:0], bus.SPI_clk};
      data_sync_q <= {data_sync_q[Sync_Stages-2:0], bus.DataBit};
      cs_sync_q   <= {cs_sync_q[Sync_Stages-2:0], bus.CS};
      sclk_dly_q  <= sclk_s;
      data_dly_q  <= data_sync_q[Sync_Stages-1];
      cs_dly_q    <= cs_s;
      sclk_rise_q <= sclk_s & ~sclk_dly_q;
      cs_rise_q   <= cs_s & ~cs_dly_q;
      cs_fall_q   <= ~cs_s & cs_dly_q;
      if (!warm_done) warm_q <= warm_q + WarmW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StWaitIdle;
      cnt_q   <= '0;
      shreg_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    word_ext                     = '0;
    word_ext[Shift_BitCount-1:0] = shreg_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    dout_d  = dout_q;
    valid_d = valid_q & ~bus.Data_Ready;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    unique case (state_q)
      // Sync chain reset values look like an idle link; wait until it reflects the real pin.
      StWaitIdle: begin
        if (warm_done && cs_s) state_d = StIdle;
      end
      StIdle: begin
        if (cs_fall_q) begin
          cnt_d   = '0;
          shreg_d = '0;
          state_d = StRecv;
        end
      end
      StRecv: begin
        // CS rise wins over a coincident SPI_clk rise.
        if (cs_rise_q) begin
          state_d = StIdle;
          if (cnt_q == CntW'(Shift_BitCount)) begin
            if (!valid_q || bus.Data_Ready) begin
              dout_d  = word_ext;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            ferr_d = 1'b1;
          end
        end else if (sclk_rise_q) begin
          shreg_d = {data_dly_q, shreg_q[Shift_BitCount-1:1]};
          if (cnt_q != CntW'(Shift_BitCount + 1)) cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StWaitIdle;
    endcase
  end

  assign bus.Data_Out    = dout_q;
  assign bus.Data_Valid  = valid_q;
  assign bus.Frame_Error = ferr_q;
  assign bus.Overrun     = ovr_q;

endmodule
